// File: rtl/mgt_01_booth_multiplier_pkg.sv
// Shared types for the radix-4 Booth multiplier block.
//   XLEN        : default machine word width
//   mul_ops_e   : multiply flavours (low half, signed/unsigned/mixed high half)
//   fu_state_e  : functional-unit occupancy reported to the issue logic
package mgt_01_booth_multiplier_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL_    = 2'd0,
        MULH_   = 2'd1,
        MULHU_  = 2'd2,
        MULHSU_ = 2'd3
    } mul_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

    // Number of radix-4 steps needed for a WIDTH-bit operand extended by 2 bits.
    function automatic int booth_steps(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/mgt_01_booth_r4_step.sv
// One radix-4 Booth iteration (purely combinational).
//   acc_i   : accumulator {hi[WIDTH+3:0], multiplier[WIDTH+1:0], L}
//   mcand_i : multiplicand, already extended to WIDTH+2 bits (signed view)
//   acc_o   : accumulator after add of the recoded partial product and an
//             arithmetic shift right by 2
module mgt_01_booth_r4_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH+6:0] acc_i,
    input  logic [WIDTH+1:0]   mcand_i,
    output logic [2*WIDTH+6:0] acc_o
);

    localparam int EXT_W = WIDTH + 2;
    localparam int HI_W  = WIDTH + 4;
    localparam int ACC_W = 2 * WIDTH + 7;

    logic        [2:0]      sel;
    logic signed [HI_W-1:0] hi;
    logic signed [HI_W-1:0] b_ext;
    logic signed [HI_W-1:0] addend;
    logic signed [HI_W-1:0] hi_sum;
    logic signed [ACC_W-1:0] sum_acc;

    assign sel   = acc_i[2:0];
    assign hi    = acc_i[ACC_W-1 -: HI_W];
    // Two guard bits keep +/-2B inside the high-part range.
    assign b_ext = {{2{mcand_i[EXT_W-1]}}, mcand_i};

    always_comb begin
        addend = '0;
        unique case (sel)
            3'b001, 3'b010: addend = b_ext;
            3'b011:         addend = b_ext <<< 1;
            3'b100:         addend = -(b_ext <<< 1);
            3'b101, 3'b110: addend = -b_ext;
            default:        addend = '0;
        endcase
    end

    assign hi_sum  = hi + addend;
    assign sum_acc = {hi_sum, acc_i[ACC_W-HI_W-1:0]};
    assign acc_o   = sum_acc >>> 2;

endmodule

// File: rtl/mgt_01_booth_multiplier.sv
// Iterative radix-4 Booth multiplier, one step per enabled cycle.
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   clk_en_i              : stall; state holds while low (kill/reset excepted)
//   kill_i                : flush, returns to IDLE and drops any result
//   valid_i / ready_o     : request handshake (operation_i, multiplicand_i, multiplier_i)
//   valid_o / ready_i     : result handshake (result_o)
//   fu_state_o            : FREE while idle, BUSY otherwise
module mgt_01_booth_multiplier
    import mgt_01_booth_multiplier_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clk_en_i,
    input  logic             kill_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  mul_ops_e         operation_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output fu_state_e        fu_state_o
);

    localparam int EXT_W   = WIDTH + 2;
    localparam int ACC_W   = 2 * WIDTH + 7;
    localparam int N_STEPS = booth_steps(WIDTH);
    localparam int CNT_W   = $clog2(N_STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [EXT_W-1:0] mcand_q, mcand_d;
    mul_ops_e         op_q, op_d;

    logic             a_signed;
    logic             b_signed;
    logic [EXT_W-1:0] mcand_ext;
    logic [EXT_W-1:0] mplier_ext;
    logic             operands_zero;
    logic [ACC_W-1:0] step_acc;

    assign a_signed   = (operation_i != MULHU_);
    assign b_signed   = (operation_i == MUL_) || (operation_i == MULH_);
    assign mcand_ext  = {{2{a_signed & multiplicand_i[WIDTH-1]}}, multiplicand_i};
    assign mplier_ext = {{2{b_signed & multiplier_i[WIDTH-1]}}, multiplier_i};
    assign operands_zero = ZERO_BYPASS &&
                           ((multiplicand_i == '0) || (multiplier_i == '0));

    mgt_01_booth_r4_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .acc_o   (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        mcand_d  = mcand_q;
        op_d     = op_q;

        if (kill_i) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            result_d = '0;
        end else if (clk_en_i) begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        op_d    = operation_i;
                        mcand_d = mcand_ext;
                        cnt_d   = '0;
                        if (operands_zero) begin
                            acc_d    = '0;
                            result_d = '0;
                            state_d  = S_DONE;
                        end else begin
                            // Multiplier sits in the low half with the Booth L bit = 0.
                            acc_d   = {{(WIDTH + 4){1'b0}}, mplier_ext, 1'b0};
                            state_d = S_COMPUTE;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc_d = step_acc;
                    cnt_d = cnt_q + CNT_W'(1);
                    // The last step's product goes straight into the result register.
                    if (cnt_q == CNT_W'(N_STEPS - 1)) begin
                        state_d  = S_DONE;
                        result_d = (op_q == MUL_) ? step_acc[WIDTH:1]
                                                  : step_acc[2*WIDTH:WIDTH+1];
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Operand/operation latches are only meaningful after an accept.
    always_ff @(posedge clk_i) begin
        mcand_q <= mcand_d;
        op_q    <= op_d;
    end

    assign ready_o    = (state_q == S_IDLE);
    assign valid_o    = (state_q == S_DONE);
    assign result_o   = result_q;
    assign fu_state_o = (state_q == S_IDLE) ? FREE : BUSY;

endmodule

// File: tb/tb_mgt_01_booth_multiplier.sv
module tb_mgt_01_booth_multiplier;
    import mgt_01_booth_multiplier_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        kill;
    logic        ready_in;
    logic        w_valid_in;
    logic        n_valid_in;
    mul_ops_e    op;
    logic [31:0] opa;
    logic [31:0] opb;

    logic        w_ready, w_valid;
    logic [31:0] w_result;
    fu_state_e   w_fs;
    logic        n_ready, n_valid;
    logic [15:0] n_result;
    fu_state_e   n_fs;

    bit          narrow;
    logic        cur_ready, cur_valid;
    logic [31:0] cur_result;
    fu_state_e   cur_fs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mgt_01_booth_multiplier #(.WIDTH(32), .ZERO_BYPASS(1'b1)) u_dut_w (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .clk_en_i       (clk_en),
        .kill_i         (kill),
        .valid_i        (w_valid_in),
        .ready_o        (w_ready),
        .operation_i    (op),
        .multiplicand_i (opa),
        .multiplier_i   (opb),
        .valid_o        (w_valid),
        .ready_i        (ready_in),
        .result_o       (w_result),
        .fu_state_o     (w_fs)
    );

    mgt_01_booth_multiplier #(.WIDTH(16), .ZERO_BYPASS(1'b1)) u_dut_n (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .clk_en_i       (clk_en),
        .kill_i         (kill),
        .valid_i        (n_valid_in),
        .ready_o        (n_ready),
        .operation_i    (op),
        .multiplicand_i (opa[15:0]),
        .multiplier_i   (opb[15:0]),
        .valid_o        (n_valid),
        .ready_i        (ready_in),
        .result_o       (n_result),
        .fu_state_o     (n_fs)
    );

    assign cur_ready  = narrow ? n_ready : w_ready;
    assign cur_valid  = narrow ? n_valid : w_valid;
    assign cur_result = narrow ? {16'h0000, n_result} : w_result;
    assign cur_fs     = narrow ? n_fs : w_fs;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference product from integer arithmetic on the extended operands.
    function automatic logic [31:0] ref_mul(input int w, input mul_ops_e o,
                                            input logic [31:0] a, input logic [31:0] b);
        logic signed [79:0] sa, sb, p;
        logic        [79:0] pu;
        logic        [31:0] m;
        m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        sa = 80'(a & m);
        sb = 80'(b & m);
        if (o != MULHU_ && a[w-1]) sa = sa - (80'sd1 <<< w);
        if ((o == MUL_ || o == MULH_) && b[w-1]) sb = sb - (80'sd1 <<< w);
        p  = sa * sb;
        pu = p;
        if (o == MUL_) return 32'(pu) & m;
        return 32'(pu >> w) & m;
    endfunction

    task automatic run_op(input bit nar, input mul_ops_e o, input logic [31:0] a,
                          input logic [31:0] b, input bit stall, input int hold);
        int          cyc;
        int          nstall;
        int          exp_lat;
        logic [31:0] m;
        logic [31:0] expv;
        narrow  = nar;
        m       = nar ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        expv    = ref_mul(nar ? 16 : 32, o, a, b);
        exp_lat = (((a & m) == 0) || ((b & m) == 0)) ? 1 : (nar ? 10 : 18);
        @(negedge clk);
        chk("ready_idle", 64'(cur_ready), 64'd1);
        op = o; opa = a; opb = b; ready_in = 1'b0;
        if (nar) n_valid_in = 1'b1; else w_valid_in = 1'b1;
        @(posedge clk); #1;
        w_valid_in = 1'b0; n_valid_in = 1'b0;
        chk("ready_busy", 64'(cur_ready), 64'd0);
        chk("fu_busy", 64'(cur_fs), 64'(BUSY));
        cyc = 1; nstall = 0;
        while (!cur_valid && cyc < 200) begin
            if (stall) begin
                clk_en = cyc[0];
                if (!clk_en) nstall++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        clk_en = 1'b1;
        chk("latency", 64'(cyc), 64'(exp_lat + nstall));
        chk("result", 64'(cur_result), 64'(expv));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(cur_valid), 64'd1);
            chk("hold_result", 64'(cur_result), 64'(expv));
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        chk("valid_drop", 64'(cur_valid), 64'd0);
        chk("ready_back", 64'(cur_ready), 64'd1);
    endtask

    task automatic accept_then_wait(input mul_ops_e o, input logic [31:0] a,
                                    input logic [31:0] b, input int steps);
        narrow = 1'b0;
        @(negedge clk);
        op = o; opa = a; opb = b; w_valid_in = 1'b1;
        @(posedge clk); #1;
        w_valid_in = 1'b0;
        repeat (steps) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit saw_valid;
        mul_ops_e ro;
        logic [31:0] ra, rb;
        bit rn;

        rst_n = 1'b0; clk_en = 1'b1; kill = 1'b0; ready_in = 1'b0;
        w_valid_in = 1'b0; n_valid_in = 1'b0; op = MUL_; opa = '0; opb = '0;
        narrow = 1'b0;
        #1;
        chk("rst_ready", 64'(w_ready), 64'd1);
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_result", 64'(w_result), 64'd0);
        chk("rst_fu", 64'(w_fs), 64'(FREE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, MUL_,    32'd7,         32'hFFFF_FFFD, 1'b0, 0);
        run_op(1'b0, MULHU_,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(1'b0, MULHSU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(1'b0, MULH_,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(1'b0, MULH_,   32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(1'b0, MUL_,    32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(1'b0, MUL_,    32'd0,         32'h1234_5678, 1'b0, 0);
        run_op(1'b0, MULHU_,  32'hFFFF_FFFF, 32'h1234_5679, 1'b1, 10);
        run_op(1'b1, MULHU_,  32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 0);

        // Kill mid-operation
        accept_then_wait(MUL_, 32'd5, 32'd6, 5);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_valid", 64'(w_valid), 64'd0);
        chk("kill_ready", 64'(w_ready), 64'd1);
        saw_valid = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (w_valid) saw_valid = 1'b1;
        end
        chk("kill_no_result", 64'(saw_valid), 64'd0);
        run_op(1'b0, MUL_, 32'd3, 32'd4, 1'b0, 0);

        // Kill beats a request in the same cycle
        @(negedge clk);
        op = MUL_; opa = 32'd9; opb = 32'd9; w_valid_in = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        w_valid_in = 1'b0; kill = 1'b0;
        chk("kill_idle_ready", 64'(w_ready), 64'd1);

        // Reset mid-operation
        accept_then_wait(MUL_, 32'd11, 32'd13, 9);
        rst_n = 1'b0;
        #1;
        chk("amid_rst_ready", 64'(w_ready), 64'd1);
        chk("amid_rst_valid", 64'(w_valid), 64'd0);
        chk("amid_rst_result", 64'(w_result), 64'd0);
        chk("amid_rst_fu", 64'(w_fs), 64'(FREE));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            rn = 1'($urandom_range(0, 1));
            ro = mul_ops_e'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 3) == 0) ra = rn ? 32'h0000_8000 : 32'h8000_0000;
            run_op(rn, ro, ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
